// File: rtl/sprite_engine.sv
// Sprite engine: reloads a sprite table from BRAM during vertical blanking into shadow slots,
// commits it atomically, and renders the lowest-index hit sprite with a registered RGB444 output.
module sprite_engine #(
    parameter int MAX_SPR     = 16,
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int RELOAD_LINE = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bright,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic [15:0]       q_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [3:0]        r,
    output logic [3:0]        g,
    output logic [3:0]        b,
    output logic              busy,
    output logic              frame_valid
);

    localparam int IDX_W = (MAX_SPR > 1) ? $clog2(MAX_SPR) : 1;
    localparam int CNT_W = $clog2(MAX_SPR + 1);
    localparam logic [15:0]       MAX16   = 16'(MAX_SPR);
    localparam logic [CNT_W-1:0]  MAXC    = CNT_W'(MAX_SPR);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [9:0]        RELOAD  = 10'(RELOAD_LINE);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, COMMIT} ld_state_t;

    ld_state_t         state;
    logic              hdr_phase;
    logic [1:0]        fld;
    logic [IDX_W-1:0]  spr_idx;
    logic [CNT_W-1:0]  eff_cnt;
    logic [CNT_W-1:0]  hdr_eff;

    logic [9:0]  sh_x   [MAX_SPR];
    logic [9:0]  sh_y   [MAX_SPR];
    logic        sh_en  [MAX_SPR];
    logic        sh_sz  [MAX_SPR];
    logic [11:0] sh_col [MAX_SPR];

    logic [9:0]  act_x   [MAX_SPR];
    logic [9:0]  act_y   [MAX_SPR];
    logic        act_en  [MAX_SPR];
    logic        act_sz  [MAX_SPR];
    logic [11:0] act_col [MAX_SPR];

    assign hdr_eff = (q_b > MAX16) ? MAXC : q_b[CNT_W-1:0];

    // Glyph pixel codes: 0 = black, 1 = sprite colour, 2 = white
    function automatic logic [1:0] round_code(input logic [3:0] dx, input logic [3:0] dy);
        logic signed [11:0] cx;
        logic signed [11:0] cy;
        logic signed [11:0] d2;
        cx = $signed({7'b0, dx, 1'b0}) - 12'sd15;
        cy = $signed({7'b0, dy, 1'b0}) - 12'sd15;
        d2 = cx * cx + cy * cy;
        return (d2 <= 12'sd256) ? 2'd1 : 2'd0;
    endfunction

    // Player face: white 2-pixel frame, black eyes and mouth, body in sprite colour
    function automatic logic [1:0] box_code(input logic [4:0] dx, input logic [4:0] dy);
        logic eye_row;
        logic eye_col;
        logic mouth;
        eye_row = (dy >= 5'd8) && (dy < 5'd12);
        eye_col = ((dx >= 5'd8) && (dx < 5'd12)) || ((dx >= 5'd20) && (dx < 5'd24));
        mouth   = (dy >= 5'd20) && (dy < 5'd23) && (dx >= 5'd8) && (dx < 5'd24);
        if ((dx < 5'd2) || (dx > 5'd29) || (dy < 5'd2) || (dy > 5'd29))
            return 2'd2;
        else if ((eye_row && eye_col) || mouth)
            return 2'd0;
        else
            return 2'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr_b      <= BASE_A;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            hdr_phase   <= 1'b0;
            fld         <= 2'd0;
            spr_idx     <= '0;
            eff_cnt     <= '0;
            for (int k = 0; k < MAX_SPR; k++) begin
                sh_x[k]    <= '0;
                sh_y[k]    <= '0;
                sh_en[k]   <= 1'b0;
                sh_sz[k]   <= 1'b0;
                sh_col[k]  <= '0;
                act_x[k]   <= '0;
                act_y[k]   <= '0;
                act_en[k]  <= 1'b0;
                act_sz[k]  <= 1'b0;
                act_col[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (vCount == RELOAD && hCount == 10'd0) begin
                        state     <= WAIT;
                        addr_b    <= BASE_A;
                        busy      <= 1'b1;
                        hdr_phase <= 1'b1;
                        fld       <= 2'd0;
                        spr_idx   <= '0;
                    end
                end
                WAIT: state <= CAPTURE;
                CAPTURE: begin
                    if (hdr_phase) begin
                        hdr_phase <= 1'b0;
                        eff_cnt   <= hdr_eff;
                        if (hdr_eff == '0) begin
                            state <= COMMIT;
                        end else begin
                            addr_b <= addr_b + ADDR_W'(1);
                            state  <= WAIT;
                        end
                    end else begin
                        case (fld)
                            2'd0: sh_x[spr_idx] <= q_b[9:0];
                            2'd1: sh_y[spr_idx] <= q_b[9:0];
                            default: begin
                                sh_en[spr_idx]  <= q_b[0];
                                sh_sz[spr_idx]  <= q_b[1];
                                sh_col[spr_idx] <= q_b[15:4];
                            end
                        endcase
                        if (fld == 2'd2 && (CNT_W'(spr_idx) + CNT_W'(1)) == eff_cnt) begin
                            state <= COMMIT;
                        end else begin
                            if (fld == 2'd2) begin
                                fld     <= 2'd0;
                                spr_idx <= spr_idx + IDX_W'(1);
                            end else begin
                                fld <= fld + 2'd1;
                            end
                            addr_b <= addr_b + ADDR_W'(1);
                            state  <= WAIT;
                        end
                    end
                end
                COMMIT: begin
                    // Slots past the loaded count may hold stale shadow data, so they are forced off
                    for (int k = 0; k < MAX_SPR; k++) begin
                        act_x[k]   <= sh_x[k];
                        act_y[k]   <= sh_y[k];
                        act_sz[k]  <= sh_sz[k];
                        act_col[k] <= sh_col[k];
                        act_en[k]  <= sh_en[k] && (CNT_W'(k) < eff_cnt);
                    end
                    frame_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic             hit_any;
    logic [IDX_W-1:0] win;
    logic [10:0]      span;
    logic             in_x;
    logic             in_y;
    logic [4:0]       dx;
    logic [4:0]       dy;
    logic [1:0]       code;
    logic [11:0]      pix_col;

    always_comb begin
        hit_any = 1'b0;
        win     = '0;
        span    = 11'd16;
        in_x    = 1'b0;
        in_y    = 1'b0;
        // Descending scan so the lowest hitting index is the one left in win
        for (int k = MAX_SPR - 1; k >= 0; k--) begin
            span = act_sz[k] ? 11'd32 : 11'd16;
            in_x = ({1'b0, hCount} >= {1'b0, act_x[k]}) && ({1'b0, hCount} < ({1'b0, act_x[k]} + span));
            in_y = ({1'b0, vCount} >= {1'b0, act_y[k]}) && ({1'b0, vCount} < ({1'b0, act_y[k]} + span));
            if (act_en[k] && in_x && in_y) begin
                hit_any = 1'b1;
                win     = IDX_W'(k);
            end
        end
        dx   = hCount[4:0] - act_x[win][4:0];
        dy   = vCount[4:0] - act_y[win][4:0];
        code = act_sz[win] ? box_code(dx, dy) : round_code(dx[3:0], dy[3:0]);
        case (code)
            2'd1:    pix_col = act_col[win];
            2'd2:    pix_col = 12'hFFF;
            default: pix_col = 12'h000;
        endcase
    end

    // Colour output stage: one cycle behind the pixel coordinates
    logic [11:0] rgb_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgb_p1 <= 12'h000;
        else
            rgb_p1 <= (bright && frame_valid && hit_any) ? pix_col : 12'h000;
    end

    assign r = rgb_p1[11:8];
    assign g = rgb_p1[7:4];
    assign b = rgb_p1[3:0];

endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: BRAM model, table loads, pixel expectations and reset cases.
module tb_sprite_engine;

    localparam int MAX_SPR = 16;
    localparam int ADDR_W  = 10;
    localparam int BASE    = 100;
    localparam int RL      = 480;

    logic              clk = 1'b0;
    logic              reset;
    logic              bright;
    logic [9:0]        hCount;
    logic [9:0]        vCount;
    logic [15:0]       q_b;
    logic [ADDR_W-1:0] addr_b;
    logic [3:0]        r, g, b;
    logic              busy;
    logic              frame_valid;

    sprite_engine #(
        .MAX_SPR(MAX_SPR), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .RELOAD_LINE(RL)
    ) dut (
        .clk(clk), .reset(reset), .bright(bright), .hCount(hCount), .vCount(vCount),
        .q_b(q_b), .addr_b(addr_b), .r(r), .g(g), .b(b),
        .busy(busy), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    always @(posedge clk) q_b <= mem[addr_b];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Table being written to BRAM, and the image the DUT should currently display
    logic [15:0] t_x [64];
    logic [15:0] t_y [64];
    logic [15:0] t_a [64];
    int          t_n;
    int          m_x [MAX_SPR];
    int          m_y [MAX_SPR];
    logic [15:0] m_a [MAX_SPR];
    int          m_n  = 0;
    bit          m_fv = 0;

    function automatic logic [11:0] glyph_ref(bit big, int dx, int dy, logic [11:0] col);
        if (!big) return ((2*dx-15)*(2*dx-15) + (2*dy-15)*(2*dy-15) <= 256) ? col : 12'h000;
        if (dx < 2 || dx > 29 || dy < 2 || dy > 29) return 12'hFFF;
        if (dy >= 8 && dy < 12 && ((dx >= 8 && dx < 12) || (dx >= 20 && dx < 24))) return 12'h000;
        if (dy >= 20 && dy < 23 && dx >= 8 && dx < 24) return 12'h000;
        return col;
    endfunction

    function automatic logic [11:0] model_pix(int h, int v, bit br);
        int w;
        if (!br || !m_fv) return 12'h000;
        for (int k = 0; k < m_n; k++) begin
            if (m_a[k][0]) begin
                w = m_a[k][1] ? 32 : 16;
                if (h >= m_x[k] && h < m_x[k] + w && v >= m_y[k] && v < m_y[k] + w)
                    return glyph_ref(m_a[k][1], h - m_x[k], v - m_y[k], m_a[k][15:4]);
            end
        end
        return 12'h000;
    endfunction

    task automatic write_mem();
        mem[BASE] = 16'(t_n);
        for (int k = 0; k < t_n; k++) begin
            mem[BASE + 1 + 3*k] = t_x[k];
            mem[BASE + 2 + 3*k] = t_y[k];
            mem[BASE + 3 + 3*k] = t_a[k];
        end
    endtask

    task automatic commit_model();
        m_n = (t_n < MAX_SPR) ? t_n : MAX_SPR;
        for (int k = 0; k < MAX_SPR; k++) begin
            m_x[k] = int'(t_x[k][9:0]);
            m_y[k] = int'(t_y[k][9:0]);
            m_a[k] = (k < m_n) ? t_a[k] : 16'h0;
        end
        m_fv = 1;
    endtask

    typedef struct {string tag; logic [11:0] exp;} sb_item_t;
    sb_item_t sb_q[$];

    always @(posedge clk) begin
        sb_item_t it;
        #1;
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.tag, {20'h0, r, g, b}, {20'h0, it.exp});
        end
    end

    task automatic pix_exp(input string tag, input int h, input int v, input bit br, input logic [11:0] exp);
        @(negedge clk);
        hCount = 10'(h); vCount = 10'(v); bright = br;
        sb_q.push_back('{tag, exp});
    endtask

    task automatic pix(input string tag, input int h, input int v, input bit br);
        pix_exp(tag, h, v, br, model_pix(h, v, br));
    endtask

    task automatic flush();
        repeat (2) @(negedge clk);
    endtask

    int busy_cnt = 0;
    int max_addr = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt++;
            if (int'(addr_b) > max_addr) max_addr = int'(addr_b);
        end
    end

    task automatic trigger(input bit clr);
        @(negedge clk);
        if (clr) begin busy_cnt = 0; max_addr = 0; end
        hCount = 10'd0; vCount = 10'(RL); bright = 1'b0;
        @(negedge clk);
        hCount = 10'd1;
    endtask

    task automatic wait_done(input string tag);
        int lim = 0;
        while (busy === 1'b1 && lim < 300) begin
            @(negedge clk);
            lim++;
        end
        check({tag, "_done"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic table_a();
        t_n = 2;
        t_x[0] = 16'd100; t_y[0] = 16'd50; t_a[0] = 16'hF003;
        t_x[1] = 16'd200; t_y[1] = 16'd60; t_a[1] = 16'h0F01;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        for (int i = 0; i < 64; i++) begin t_x[i] = 0; t_y[i] = 0; t_a[i] = 0; end
        reset = 1'b1; bright = 1'b0; hCount = 10'd1; vCount = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_fv", {31'h0, frame_valid}, 32'h0);
        check("rst_rgb", {20'h0, r, g, b}, 32'h0);
        check("rst_addr", 32'(addr_b), 32'(BASE));
        reset = 1'b0;
        pix_exp("pre_load", 100, 50, 1, 12'h000);
        flush();

        // Two-sprite table
        table_a(); write_mem();
        trigger(1); wait_done("a");
        check("a_busy_len", busy_cnt, 15);
        check("a_fv", {31'h0, frame_valid}, 32'h1);
        check("a_max_addr", max_addr, BASE + 6);
        commit_model();
        pix_exp("a_box_corner", 100, 50, 1, 12'hFFF);
        pix_exp("a_round_row0", 207, 60, 1, 12'h0F0);
        pix_exp("a_round_corner", 200, 60, 1, 12'h000);
        pix_exp("a_box_body", 115, 65, 1, 12'hF00);
        pix_exp("a_box_eye", 110, 60, 1, 12'h000);
        pix_exp("a_dark", 115, 65, 0, 12'h000);
        pix_exp("a_box_lastcol", 131, 50, 1, 12'hFFF);
        pix_exp("a_box_right", 132, 50, 1, 12'h000);
        pix_exp("a_left", 99, 50, 1, 12'h000);
        pix_exp("a_round_mid", 215, 67, 1, 12'h0F0);
        pix_exp("a_round_out", 216, 67, 1, 12'h000);
        for (int h = 196; h < 220; h++) pix($sformatf("a_scan%0d", h), h, 63, 1);
        flush();

        // New table written while A is on screen; retrigger during the load is ignored
        t_n = 3;
        t_x[0] = 16'd300;  t_y[0] = 16'd300; t_a[0] = 16'hF001;
        pix("b_mid_a", 115, 65, 1);
        t_x[1] = 16'd300;  t_y[1] = 16'd300; t_a[1] = 16'h00F1;
        t_x[2] = 16'd1010; t_y[2] = 16'd700; t_a[2] = 16'h0F03;
        write_mem();
        flush();
        trigger(1);
        pix_exp("b_old_box", 100, 50, 1, 12'hFFF);
        pix_exp("b_new_hidden", 307, 307, 1, 12'h000);
        trigger(0);
        pix_exp("b_old_round", 207, 60, 1, 12'h0F0);
        wait_done("b");
        check("b_busy_len", busy_cnt, 21);
        check("b_max_addr", max_addr, BASE + 9);
        commit_model();
        pix_exp("b_overlap", 307, 307, 1, 12'hF00);
        pix_exp("b_overlap_r0", 305, 300, 1, 12'hF00);
        pix_exp("b_old_gone", 100, 50, 1, 12'h000);
        pix_exp("b_edge_body", 1015, 705, 1, 12'h0F0);
        pix_exp("b_edge_last", 1023, 705, 1, 12'h0F0);
        pix_exp("b_edge_nowrap", 5, 705, 1, 12'h000);
        for (int h = 298; h < 318; h++) pix($sformatf("b_scan%0d", h), h, 308, 1);
        flush();

        // Header count above the slot limit
        t_n = 40;
        for (int k = 0; k < 40; k++) begin
            if (k < 16) begin
                t_x[k] = 16'(k * 60); t_y[k] = 16'd400; t_a[k] = {12'((k + 1) * 12'h111), 4'h1};
            end else begin
                t_x[k] = 16'((k - 16) * 40); t_y[k] = 16'd200; t_a[k] = 16'hABC3;
            end
        end
        write_mem();
        trigger(1); wait_done("c");
        check("c_busy_len", busy_cnt, 99);
        check("c_max_addr", max_addr, BASE + 48);
        commit_model();
        for (int k = 0; k < 16; k++) pix($sformatf("c_slot%0d", k), k * 60 + 7, 407, 1);
        pix_exp("c_slot15", 907, 407, 1, 12'h110);
        pix_exp("c_extra20", 170, 210, 1, 12'h000);
        flush();

        // Reset in the middle of a load
        trigger(1);
        hCount = 10'd7; vCount = 10'd407; bright = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("d_pre_rst_rgb", {20'h0, r, g, b}, {20'h0, model_pix(7, 407, 1)});
        check("d_pre_rst_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("d_rst_busy", {31'h0, busy}, 32'h0);
        check("d_rst_fv", {31'h0, frame_valid}, 32'h0);
        check("d_rst_rgb", {20'h0, r, g, b}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_fv = 0; m_n = 0;
        pix_exp("d_after_rst", 7, 407, 1, 12'h000);
        flush();
        table_a(); write_mem();
        trigger(1); wait_done("d");
        check("d_busy_len", busy_cnt, 15);
        check("d_fv", {31'h0, frame_valid}, 32'h1);
        commit_model();
        pix_exp("d_box_corner", 100, 50, 1, 12'hFFF);
        pix_exp("d_round_row0", 207, 60, 1, 12'h0F0);
        pix_exp("d_stale_slot", 7, 407, 1, 12'h000);
        flush();

        // Empty table
        t_n = 0; write_mem();
        trigger(1); wait_done("e");
        check("e_busy_len", busy_cnt, 3);
        check("e_fv", {31'h0, frame_valid}, 32'h1);
        commit_model();
        pix_exp("e_black_box", 115, 65, 1, 12'h000);
        pix_exp("e_black_round", 207, 60, 1, 12'h000);
        for (int h = 100; h < 110; h++) pix($sformatf("e_scan%0d", h), h, 52, 1);
        flush();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 SHALL have parameter MAX_SPR, default 16: number of sprite slots, 1..32.
REQ-002 SHALL have parameter ADDR_W, default 10: BRAM address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0: BRAM address of the sprite-table header word.
REQ-004 SHALL have parameter RELOAD_LINE, default 480: vCount value that triggers a table reload.
REQ-005 SHALL have port clk, input, 1: single clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port bright, input, 1: visible-area flag.
REQ-008 SHALL have ports hCount and vCount, input, 10 each: pixel coordinates.
REQ-009 SHALL have ports q_b (input, 16: BRAM read data) and addr_b (output, ADDR_W: BRAM read address).
REQ-010 SHALL have ports r, g, b, output, 4 each: registered colour.
REQ-011 SHALL have port busy, output, 1: high while a table load is in progress.
REQ-012 SHALL have port frame_valid, output, 1: high once at least one table has been committed.

Function
REQ-013 Table layout SHALL be: word BASE_ADDR = sprite count N; sprite k occupies BASE_ADDR+1+3k (X), +2+3k (Y) and +3+3k (attr).
REQ-014 Attr bits SHALL be: [0] enable; [1] size (0 = 16x16 round obstacle glyph, 1 = 32x32 box-face player glyph); [15:4] RGB444 colour.
REQ-015 X and Y SHALL use q_b[9:0].
REQ-016 The BRAM read SHALL be timed so q_b is sampled exactly 2 clk edges after the edge that updates addr_b.
REQ-017 The loader SHALL use states IDLE, WAIT, CAPTURE and COMMIT.
REQ-018 IDLE -> WAIT SHALL occur on the first cycle with vCount==RELOAD_LINE && hCount==0; addr_b<=BASE_ADDR and busy<=1 on that edge.
REQ-019 WAIT SHALL last one cycle, then go to CAPTURE.
REQ-020 CAPTURE SHALL store q_b into the shadow field selected by (word index, sprite index).
REQ-021 From CAPTURE, if more words remain, addr_b SHALL increment and the FSM SHALL return to WAIT; otherwise it SHALL go to COMMIT.
REQ-022 Effective count SHALL be min(N, MAX_SPR), giving 1+3*min(N,MAX_SPR) words read.
REQ-023 N==0 SHALL read only the header and then go to COMMIT.
REQ-024 COMMIT SHALL copy all shadow slots to the active slots in one edge.
REQ-025 COMMIT SHALL disable (enable=0) active slots with index >= effective count.
REQ-026 COMMIT SHALL set frame_valid<=1 and busy<=0, then return to IDLE.
REQ-027 Load latency SHALL be 2*(1+3*min(N,MAX_SPR))+1 cycles from trigger edge to busy falling.
REQ-028 A trigger condition occurring while busy SHALL be ignored (no restart).
REQ-029 The renderer SHALL read active slots only; shadow writes SHALL never be visible mid-frame.
REQ-030 Pixel hit for slot k SHALL require: enable && hCount in [X, X+W) && vCount in [Y, Y+H), with W=H=16 or 32 per the size bit.
REQ-031 Hit comparisons SHALL use 11-bit sums so X+W beyond 1023 does not wrap.
REQ-032 When multiple slots hit on a pixel, the lowest slot index SHALL win; colour = that slot's attr[15:4].
REQ-033 r,g,b SHALL register one cycle after the hCount/vCount/bright they correspond to.
REQ-034 Output SHALL be 12'h000 when !bright, !frame_valid, or no slot hits.

Reset
REQ-035 Reset SHALL asynchronously force: loader IDLE; addr_b=BASE_ADDR; busy=0; frame_valid=0; r,g,b=0; all shadow and active slots zero (disabled).
REQ-036 Reset asserted mid-load SHALL abandon the load with no commit.
REQ-037 After reset release, the first load SHALL start at the next trigger.

Verification
REQ-038 Table N=2 {X=100,Y=50,attr=16'hF003; X=200,Y=60,attr=16'h0F01}, trigger -> busy high exactly 15 cycles; frame_valid=1; pixel (100,50) gives FFF; pixel (207,60) gives 0F0 (glyph row0 bit set); pixel (200,60) gives 000.
REQ-039 Overlap: slot0 and slot1 both at (300,300), colours F00/00F -> (300,300)-area hits show F00 only.
REQ-040 N=40 with MAX_SPR=16 -> exactly 49 words read (addr_b max = BASE_ADDR+48); load completes; slots 0..15 drawn.
REQ-041 Modify BRAM mid-frame and retrigger while busy -> active image unchanged until COMMIT; second trigger ignored.
REQ-042 Reset asserted at the cycle-7 CAPTURE of a load -> busy=0, frame_valid=0, RGB 000 immediately (asynchronously); next trigger performs a full clean load.
REQ-043 N=0 -> busy for 3 cycles; all slots disabled; screen black while frame_valid=1.
